// File: rtl/spi_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_apb_pkg
// Description : Register map, bit positions and APB phase encoding shared by
//               the SPI APB controller and its RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_apb_pkg;

    // Register select, taken from PADDR[3:2]
    localparam logic [1:0] c_reg_ctrl   = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_txdata = 2'd2;
    localparam logic [1:0] c_reg_rxdata = 2'd3;

    localparam int c_ctrl_apb_mode  = 0;
    localparam int c_ctrl_rx_irq_en = 1;
    localparam int c_ctrl_tx_irq_en = 2;

    localparam int c_st_rx_empty   = 0;
    localparam int c_st_rx_full    = 1;
    localparam int c_st_rx_ovf     = 2;
    localparam int c_st_tx_pending = 3;
    localparam int c_st_tx_udf     = 4;
    localparam int c_st_tx_ovw     = 5;
    localparam int c_st_rx_count   = 8;

    localparam logic [1:0] c_apb_idle   = 2'd0;
    localparam logic [1:0] c_apb_setup  = 2'd1;
    localparam logic [1:0] c_apb_access = 2'd2;

endpackage
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_fifo
// Description : Synchronous FIFO for received SPI words. A push into a full
//               FIFO is dropped and flagged unless a pop frees a slot.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW     = $clog2(DEPTH);
    localparam int             CW     = AW + 1;
    localparam logic [AW:0]    c_full = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == c_full);
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push
    assign w_do_push = push & (~full | w_do_pop);
    assign overflow  = push & ~w_do_push;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_apb_ctrl
// Description : APB3 slave that feeds the SPI TX holding word, buffers
//               received SPI words and raises a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_apb_ctrl
    import spi_apb_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [9:0]        spi_rx_data,
    input  logic              spi_rx_valid,
    input  logic              spi_tx_valid,
    output logic [7:0]        spi_tx_data,
    output logic              spi_apb_mode,
    output logic              irq
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic [1:0]        r_state;
    logic              r_apb_mode;
    logic              r_rx_irq_en;
    logic              r_tx_irq_en;
    logic [7:0]        r_tx_data;
    logic              r_tx_pending;
    logic              r_tx_udf;
    logic              r_tx_ovw;
    logic              r_rx_ovf;
    logic              r_tx_valid_q;
    logic              r_tx_edge;
    logic              r_irq;

    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    logic [1:0]        w_sel;
    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic              w_wr_tx;
    logic              w_rd_rx;
    logic              w_fifo_pop;
    logic [9:0]        w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_ovf;
    logic [CW-1:0]     w_fifo_count;
    logic              w_tx_udf_set;
    logic              w_tx_ovw_set;
    logic [DATA_W-1:0] w_status;
    logic              w_unused;

    // Only an enable phase that follows a setup phase counts as an access
    assign w_access    = PSEL & PENABLE & (r_state == c_apb_setup);
    assign w_wr        = w_access & PWRITE;
    assign w_rd        = w_access & ~PWRITE;
    assign w_sel       = PADDR[3:2];
    assign w_wr_ctrl   = w_wr & (w_sel == c_reg_ctrl);
    assign w_wr_status = w_wr & (w_sel == c_reg_status);
    assign w_wr_tx     = w_wr & (w_sel == c_reg_txdata);
    assign w_rd_rx     = w_rd & (w_sel == c_reg_rxdata);
    assign w_fifo_pop  = w_rd_rx & ~w_fifo_empty;
    assign w_unused    = ^{PADDR, PWDATA};

    assign w_tx_udf_set = r_tx_edge & ~r_tx_pending & ~w_wr_tx;
    assign w_tx_ovw_set = w_wr_tx & r_tx_pending;

    spi_rx_fifo #(
        .W     (10),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (spi_rx_valid),
        .push_data (spi_rx_data),
        .pop       (w_fifo_pop),
        .head      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .overflow  (w_fifo_ovf),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_apb_idle;
        end else if (PSEL & ~PENABLE) begin
            r_state <= c_apb_setup;
        end else if (w_access) begin
            r_state <= c_apb_access;
        end else begin
            r_state <= c_apb_idle;
        end
    end

    always_comb begin
        w_status                         = '0;
        w_status[c_st_rx_empty]          = w_fifo_empty;
        w_status[c_st_rx_full]           = w_fifo_full;
        w_status[c_st_rx_ovf]            = r_rx_ovf;
        w_status[c_st_tx_pending]        = r_tx_pending;
        w_status[c_st_tx_udf]            = r_tx_udf;
        w_status[c_st_tx_ovw]            = r_tx_ovw;
        w_status[c_st_rx_count +: CW]    = w_fifo_count;
    end

    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (w_sel)
                c_reg_ctrl:   PRDATA = DATA_W'({r_tx_irq_en, r_rx_irq_en, r_apb_mode});
                c_reg_status: PRDATA = w_status;
                c_reg_rxdata: PRDATA = w_fifo_empty ? '0 : DATA_W'(w_fifo_head);
                default:      PRDATA = '0;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & ((~PWRITE & (w_sel == c_reg_txdata)) |
                                 ( PWRITE & (w_sel == c_reg_rxdata)) |
                                 (w_rd_rx & w_fifo_empty));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_apb_mode   <= 1'b0;
            r_rx_irq_en  <= 1'b0;
            r_tx_irq_en  <= 1'b0;
            r_tx_data    <= '0;
            r_tx_pending <= 1'b0;
            r_tx_udf     <= 1'b0;
            r_tx_ovw     <= 1'b0;
            r_rx_ovf     <= 1'b0;
            r_tx_valid_q <= 1'b0;
            r_tx_edge    <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_apb_mode  <= PWDATA[c_ctrl_apb_mode];
                r_rx_irq_en <= PWDATA[c_ctrl_rx_irq_en];
                r_tx_irq_en <= PWDATA[c_ctrl_tx_irq_en];
            end
            r_tx_valid_q <= spi_tx_valid;
            r_tx_edge    <= spi_tx_valid & ~r_tx_valid_q;
            // A software write in the consume cycle keeps the new word pending
            if (w_wr_tx) begin
                r_tx_data    <= PWDATA[7:0];
                r_tx_pending <= 1'b1;
            end else if (r_tx_edge) begin
                r_tx_pending <= 1'b0;
            end
            r_tx_udf <= w_tx_udf_set | (r_tx_udf & ~(w_wr_status & PWDATA[c_st_tx_udf]));
            r_tx_ovw <= w_tx_ovw_set | (r_tx_ovw & ~(w_wr_status & PWDATA[c_st_tx_ovw]));
            r_rx_ovf <= w_fifo_ovf   | (r_rx_ovf & ~(w_wr_status & PWDATA[c_st_rx_ovf]));
            r_irq    <= (r_rx_irq_en & ~w_fifo_empty) | (r_tx_irq_en & ~r_tx_pending) |
                        r_rx_ovf | r_tx_udf;
        end
    end

    assign spi_tx_data  = r_tx_data;
    assign spi_apb_mode = r_apb_mode;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_spi_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_apb_ctrl
// Description : Scenario bench for spi_apb_ctrl with an RX word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_apb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [3:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [9:0]  spi_rx_data = '0;
    logic        spi_rx_valid = 1'b0;
    logic        spi_tx_valid = 1'b0;
    logic [7:0]  spi_tx_data;
    logic        spi_apb_mode;
    logic        irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [9:0]  sb_q[$];
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    spi_apb_ctrl #(.RX_DEPTH(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_apb_mode (spi_apb_mode),
        .irq          (irq)
    );

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output logic err);
        @(posedge clk) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge clk) #1;
        PENABLE = 1'b1;
        #2 err = PSLVERR;
        @(posedge clk) #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic err);
        @(posedge clk) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge clk) #1;
        PENABLE = 1'b1;
        #2 data = PRDATA; err = PSLVERR;
        @(posedge clk) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rx_push(input logic [9:0] d);
        @(posedge clk) #1;
        spi_rx_valid = 1'b1; spi_rx_data = d;
        if (sb_q.size() < 4) sb_q.push_back(d);
        else exp_ovf = 1'b1;
        @(posedge clk) #1;
        spi_rx_valid = 1'b0;
    endtask

    task automatic tx_consume();
        @(posedge clk) #1 spi_tx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 spi_tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
        n_tests++; if (spi_apb_mode !== 1'b0) begin n_fail++; $display("FAIL reset_mode got=%b exp=0", spi_apb_mode); end
        n_tests++; if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_idle_bus prdata=%h pslverr=%b exp 0/0", PRDATA, PSLVERR); end
        apb_read(4'h0, d, e);
        n_tests++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl got=%h err=%b exp=0", d, e); end
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL reset_status got=%h exp=1", d); end
    endtask

    task automatic test_tx();
        logic [31:0] d; logic e;
        apb_write(4'h0, 32'h1, e);
        apb_write(4'h8, 32'hA5, e);
        n_tests++; if (spi_apb_mode !== 1'b1) begin n_fail++; $display("FAIL tx_mode got=%b exp=1", spi_apb_mode); end
        n_tests++; if (spi_tx_data !== 8'hA5) begin n_fail++; $display("FAIL tx_data got=%h exp=a5", spi_tx_data); end
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h9) begin n_fail++; $display("FAIL tx_pending_set got=%h exp=9", d); end
        tx_consume();
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL tx_consumed got=%h exp=1", d); end
        apb_write(4'h0, 32'h5, e);
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tx_irq_en got=%b exp=1", irq); end
        apb_write(4'h0, 32'h1, e);
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL tx_irq_off got=%b exp=0", irq); end
    endtask

    task automatic test_rx();
        logic [31:0] d; logic e; logic [9:0] x;
        rx_push(10'h2F1);
        rx_push(10'h0C3);
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h200) begin n_fail++; $display("FAIL rx_count2 got=%h exp=200", d); end
        repeat (2) begin
            x = sb_q.pop_front();
            apb_read(4'hC, d, e);
            n_tests++; if (d !== {22'b0, x} || e !== 1'b0) begin n_fail++; $display("FAIL rx_pop got=%h err=%b exp=%h", d, e, x); end
        end
        apb_read(4'hC, d, e);
        n_tests++; if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL rx_pop_empty got=%h err=%b exp=0/1", d, e); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic e;
        exp_ovf = 1'b0;
        for (int i = 0; i < 5; i++) rx_push(10'(10'h100 + i * 3));
        apb_read(4'h4, d, e);
        n_tests++; if (d !== {21'b0, 3'd4, 5'b0, exp_ovf, 2'b10}) begin n_fail++; $display("FAIL ovf_status got=%h exp=406", d); end
        @(posedge clk) #1;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq got=%b exp=1", irq); end
        apb_write(4'h4, 32'h4, e);
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL w1c_err got=%b exp=0", e); end
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h402) begin n_fail++; $display("FAIL ovf_clear got=%h exp=402", d); end
        @(posedge clk) #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; logic [9:0] x;
        @(posedge clk) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'hC;
        @(posedge clk) #1;
        PENABLE = 1'b1; spi_rx_valid = 1'b1; spi_rx_data = 10'h155;
        x = sb_q.pop_front();
        sb_q.push_back(10'h155);
        #2 d = PRDATA;
        n_tests++; if (d !== {22'b0, x} || PREADY !== 1'b1) begin n_fail++; $display("FAIL b2b_pop got=%h ready=%b exp=%h", d, PREADY, x); end
        @(posedge clk) #1;
        PSEL = 1'b0; PENABLE = 1'b0; spi_rx_valid = 1'b0;
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h402) begin n_fail++; $display("FAIL b2b_status got=%h exp=402", d); end
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            apb_read(4'hC, d, e);
            n_tests++; if (d !== {22'b0, x}) begin n_fail++; $display("FAIL b2b_drain got=%h exp=%h", d, x); end
        end
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL b2b_empty got=%h exp=1", d); end
    endtask

    task automatic test_tx_errors();
        logic [31:0] d; logic e;
        tx_consume();
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h11) begin n_fail++; $display("FAIL tx_udf got=%h exp=11", d); end
        @(posedge clk) #1;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL udf_irq got=%b exp=1", irq); end
        apb_write(4'h8, 32'h11, e);
        apb_write(4'h8, 32'h22, e);
        n_tests++; if (spi_tx_data !== 8'h22) begin n_fail++; $display("FAIL tx_ovw_data got=%h exp=22", spi_tx_data); end
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h39) begin n_fail++; $display("FAIL tx_ovw got=%h exp=39", d); end
        apb_write(4'h4, 32'h30, e);
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h9) begin n_fail++; $display("FAIL tx_w1c got=%h exp=9", d); end
        apb_read(4'h8, d, e);
        n_tests++; if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL txdata_read got=%h err=%b exp=0/1", d, e); end
        apb_write(4'hC, 32'h1, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL rxdata_write err=%b exp=1", e); end
        // Enable phase with no preceding setup must be ignored
        @(posedge clk) #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 4'h0; PWDATA = 32'h0;
        #2;
        n_tests++; if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL orphan_err got=%b exp=0", PSLVERR); end
        @(posedge clk) #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(4'h0, d, e);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL orphan_ctrl got=%h exp=1", d); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] d; logic e;
        rx_push(10'h3AA);
        @(posedge clk) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h0; PWDATA = 32'h7;
        @(posedge clk) #1;
        PENABLE = 1'b1; rst = 1'b1;
        @(posedge clk) #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;
        sb_q.delete();
        n_tests++; if (spi_apb_mode !== 1'b0 || spi_tx_data !== 8'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outs mode=%b tx=%h irq=%b exp 0/00/0", spi_apb_mode, spi_tx_data, irq);
        end
        apb_read(4'h0, d, e);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_ctrl got=%h exp=0", d); end
        apb_read(4'h4, d, e);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL midrst_status got=%h exp=1", d); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_overflow();
        test_back_to_back();
        test_tx_errors();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
